// File: rtl/instr_pkg.sv
// Field map, state encoding and small helpers shared by the instruction dispatcher.
package instr_pkg;

    localparam int unsigned TGT_MSB  = 63;
    localparam int unsigned TGT_LSB  = 60;
    localparam int unsigned OP_MSB   = 59;
    localparam int unsigned OP_LSB   = 56;
    localparam int unsigned ADDR_MSB = 55;
    localparam int unsigned ADDR_LSB = 32;
    localparam int unsigned ARG_MSB  = 31;
    localparam int unsigned ARG_LSB  = 0;

    localparam logic [3:0] BCAST_TGT = 4'hF;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitLow = 2'd1,
        StDecode  = 2'd2,
        StIssue   = 2'd3
    } state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic inc);
        return (inc && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/instr_timeout_cnt.sv
// Loadable up-counter that raises term_o while the count equals TERM_VAL and holds there.
module instr_timeout_cnt #(
    parameter int unsigned W        = 16,
    parameter int unsigned TERM_VAL = 65534
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         term_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign term_o = (cnt_q == W'(TERM_VAL));

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && !term_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_dispatcher.sv
// Pops 64-bit instruction words and issues them to per-target valid/ack consumers.
// Optional statistics counters are built when DISP_STATS_EN is defined.
module instr_dispatcher
    import instr_pkg::*;
#(
    parameter int unsigned N_TARGETS      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned TO_W           = 16
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [63:0]          IN_DATA,
    input  logic                 IN_VALID,
    output logic                 IN_RD,
    output logic [N_TARGETS-1:0] CMD_VALID,
    output logic [3:0]           CMD_OP,
    output logic [23:0]          CMD_ADDR,
    output logic [31:0]          CMD_ARG,
    input  logic [N_TARGETS-1:0] CMD_ACK,
    output logic                 BUSY,
    output logic                 ERR_BADTGT,
    output logic                 ERR_TIMEOUT,
    output logic [15:0]          STAT_OK,
    output logic [15:0]          STAT_BAD,
    output logic [15:0]          STAT_TO
);

    state_e               state_q, state_d;
    logic [63:0]          hold_q, hold_d;
    logic [N_TARGETS-1:0] mask_q, mask_d;
    logic [N_TARGETS-1:0] acked_q, acked_d;
    logic                 in_rd_q, in_rd_d;
    logic                 err_bad_q, err_bad_d;
    logic                 err_to_q, err_to_d;
    logic                 to_load, to_en, to_term;
    logic                 all_acked;
    logic [3:0]           tgt;

    assign tgt       = hold_q[TGT_MSB:TGT_LSB];
    assign all_acked = ((acked_q | (CMD_ACK & mask_q)) == mask_q);

    instr_timeout_cnt #(
        .W        (TO_W),
        .TERM_VAL (TIMEOUT_CYCLES - 1)
    ) u_timeout (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .load_i     (to_load),
        .load_val_i ('0),
        .en_i       (to_en),
        .term_o     (to_term)
    );

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        mask_d    = mask_q;
        acked_d   = acked_q;
        in_rd_d   = 1'b0;
        err_bad_d = 1'b0;
        err_to_d  = 1'b0;
        to_load   = 1'b0;
        to_en     = 1'b0;
        case (state_q)
            StIdle: begin
                if (IN_VALID) begin
                    hold_d  = IN_DATA;
                    in_rd_d = 1'b1;
                    state_d = StWaitLow;
                end
            end
            // Wait for the receive block to retire the popped word.
            StWaitLow: begin
                if (!IN_VALID) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                acked_d = '0;
                to_load = 1'b1;
                if (tgt == BCAST_TGT) begin
                    mask_d  = '1;
                    state_d = StIssue;
                end else if (32'(tgt) < N_TARGETS) begin
                    mask_d  = N_TARGETS'(1) << tgt;
                    state_d = StIssue;
                end else begin
                    err_bad_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            StIssue: begin
                to_en   = 1'b1;
                acked_d = acked_q | (CMD_ACK & mask_q);
                // A final ack in the timeout cycle still counts as success.
                if (all_acked) begin
                    state_d = StIdle;
                end else if (to_term) begin
                    err_to_d = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= StIdle;
            hold_q    <= '0;
            mask_q    <= '0;
            acked_q   <= '0;
            in_rd_q   <= 1'b0;
            err_bad_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            mask_q    <= mask_d;
            acked_q   <= acked_d;
            in_rd_q   <= in_rd_d;
            err_bad_q <= err_bad_d;
            err_to_q  <= err_to_d;
        end
    end

    assign IN_RD       = in_rd_q;
    assign CMD_VALID   = (state_q == StIssue) ? (mask_q & ~acked_q) : '0;
    assign CMD_OP      = hold_q[OP_MSB:OP_LSB];
    assign CMD_ADDR    = hold_q[ADDR_MSB:ADDR_LSB];
    assign CMD_ARG     = hold_q[ARG_MSB:ARG_LSB];
    assign BUSY        = (state_q != StIdle);
    assign ERR_BADTGT  = err_bad_q;
    assign ERR_TIMEOUT = err_to_q;

`ifdef DISP_STATS_EN
    logic [15:0] stat_ok_q, stat_ok_d;
    logic [15:0] stat_bad_q, stat_bad_d;
    logic [15:0] stat_to_q, stat_to_d;

    always_comb begin
        stat_ok_d  = sat_inc16(stat_ok_q, (state_q == StIssue) && all_acked);
        stat_bad_d = sat_inc16(stat_bad_q, err_bad_q);
        stat_to_d  = sat_inc16(stat_to_q, err_to_q);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            stat_ok_q  <= '0;
            stat_bad_q <= '0;
            stat_to_q  <= '0;
        end else begin
            stat_ok_q  <= stat_ok_d;
            stat_bad_q <= stat_bad_d;
            stat_to_q  <= stat_to_d;
        end
    end

    assign STAT_OK  = stat_ok_q;
    assign STAT_BAD = stat_bad_q;
    assign STAT_TO  = stat_to_q;
`else
    assign STAT_OK  = '0;
    assign STAT_BAD = '0;
    assign STAT_TO  = '0;
`endif

endmodule

// File: tb/tb_instr_dispatcher.sv
// Table-driven bench for instr_dispatcher with an issue scoreboard and a per-target ack model.
module tb_instr_dispatcher;

    localparam int unsigned N_TGT = 4;
    localparam int unsigned TO    = 20;

    logic             CLK;
    logic             RESET_N;
    logic [63:0]      IN_DATA;
    logic             IN_VALID;
    logic             IN_RD;
    logic [N_TGT-1:0] CMD_VALID;
    logic [3:0]       CMD_OP;
    logic [23:0]      CMD_ADDR;
    logic [31:0]      CMD_ARG;
    logic [N_TGT-1:0] CMD_ACK;
    logic             BUSY;
    logic             ERR_BADTGT;
    logic             ERR_TIMEOUT;
    logic [15:0]      STAT_OK;
    logic [15:0]      STAT_BAD;
    logic [15:0]      STAT_TO;

    instr_dispatcher #(
        .N_TARGETS      (N_TGT),
        .TIMEOUT_CYCLES (TO),
        .TO_W           (16)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .IN_DATA     (IN_DATA),
        .IN_VALID    (IN_VALID),
        .IN_RD       (IN_RD),
        .CMD_VALID   (CMD_VALID),
        .CMD_OP      (CMD_OP),
        .CMD_ADDR    (CMD_ADDR),
        .CMD_ARG     (CMD_ARG),
        .CMD_ACK     (CMD_ACK),
        .BUSY        (BUSY),
        .ERR_BADTGT  (ERR_BADTGT),
        .ERR_TIMEOUT (ERR_TIMEOUT),
        .STAT_OK     (STAT_OK),
        .STAT_BAD    (STAT_BAD),
        .STAT_TO     (STAT_TO)
    );

    typedef struct {
        logic [63:0]          word;
        logic [N_TGT-1:0][7:0] dly;  // ack in the Nth cycle the bit is high; 0 = never
        int unsigned          hold; // extra cycles IN_VALID stays high after IN_RD
        logic [N_TGT-1:0]     exp_mask;
        logic                 exp_bad;
        logic                 exp_to;
    } vec_t;

    typedef struct {
        logic [3:0]       op;
        logic [23:0]      addr;
        logic [31:0]      arg;
        logic [N_TGT-1:0] mask;
    } exp_cmd_t;

    exp_cmd_t exp_q[$];
    vec_t     vecs[11];
    int       checks = 0;
    int       errors = 0;
    int       n_ok   = 0;
    int       n_bad  = 0;
    int       n_to   = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_stat(input int n);
`ifdef DISP_STATS_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic check_stats(input string tag);
        chk({tag, "_stat_ok"}, 64'(STAT_OK), 64'(exp_stat(n_ok)));
        chk({tag, "_stat_bad"}, 64'(STAT_BAD), 64'(exp_stat(n_bad)));
        chk({tag, "_stat_to"}, 64'(STAT_TO), 64'(exp_stat(n_to)));
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        exp_cmd_t         e;
        exp_cmd_t         cur;
        int unsigned      hi[N_TGT];
        int unsigned      rd_n, bad_n, to_n, first_k, exp_hi;
        logic [N_TGT-1:0] prev;
        logic             done;
        rd_n = 0; bad_n = 0; to_n = 0; first_k = 0; prev = '0; done = 1'b0;
        for (int t = 0; t < N_TGT; t++) hi[t] = 0;
        e.op   = v.word[59:56];
        e.addr = v.word[55:32];
        e.arg  = v.word[31:0];
        e.mask = v.exp_mask;
        cur    = e;
        if (v.exp_mask != '0) exp_q.push_back(e);
        IN_DATA  = v.word;
        IN_VALID = 1'b1;
        for (int unsigned k = 1; k <= 200; k++) begin
            tick();
            if (IN_RD) rd_n++;
            if (ERR_BADTGT) bad_n++;
            if (ERR_TIMEOUT) to_n++;
            if (k == 1) chk($sformatf("v%0d_rd_latency", idx), 64'(IN_RD), 64'd1);
            for (int t = 0; t < N_TGT; t++) if (CMD_VALID[t]) hi[t]++;
            if (CMD_VALID != '0 && prev == '0) begin
                if (first_k == 0) first_k = k;
                if (exp_q.size() == 0) begin
                    chk($sformatf("v%0d_unexpected_issue", idx), 64'(CMD_VALID), 64'd0);
                end else begin
                    cur = exp_q.pop_front();
                    chk($sformatf("v%0d_issue_mask", idx), 64'(CMD_VALID), 64'(cur.mask));
                end
            end
            if (CMD_VALID != '0) begin
                chk($sformatf("v%0d_op", idx), 64'(CMD_OP), 64'(cur.op));
                chk($sformatf("v%0d_addr", idx), 64'(CMD_ADDR), 64'(cur.addr));
                chk($sformatf("v%0d_arg", idx), 64'(CMD_ARG), 64'(cur.arg));
            end
            for (int t = 0; t < N_TGT; t++) begin
                if (CMD_VALID[t]) CMD_ACK[t] = (hi[t] == 32'(v.dly[t]));
                else              CMD_ACK[t] = 1'($urandom_range(0, 1));
            end
            prev = CMD_VALID;
            if (k == 2 + v.hold) begin
                IN_VALID = 1'b0;
                IN_DATA  = {$urandom, $urandom};
            end
            if (k >= 2 + v.hold && !BUSY) begin
                done = 1'b1;
                break;
            end
        end
        CMD_ACK = '0;
        chk($sformatf("v%0d_return_idle", idx), 64'(done), 64'd1);
        tick();
        if (IN_RD) rd_n++;
        if (ERR_BADTGT) bad_n++;
        if (ERR_TIMEOUT) to_n++;
        chk($sformatf("v%0d_pop_count", idx), 64'(rd_n), 64'd1);
        chk($sformatf("v%0d_err_badtgt", idx), 64'(bad_n), 64'(v.exp_bad));
        chk($sformatf("v%0d_err_timeout", idx), 64'(to_n), 64'(v.exp_to));
        chk($sformatf("v%0d_queue_drained", idx), 64'(exp_q.size()), 64'd0);
        if (v.exp_mask != '0)
            chk($sformatf("v%0d_issue_latency", idx), 64'(first_k), 64'(4 + v.hold));
        for (int t = 0; t < N_TGT; t++) begin
            if (!v.exp_mask[t])                               exp_hi = 0;
            else if (v.dly[t] != 8'd0 && 32'(v.dly[t]) <= TO) exp_hi = 32'(v.dly[t]);
            else                                              exp_hi = TO;
            chk($sformatf("v%0d_valid_cycles_t%0d", idx, t), 64'(hi[t]), 64'(exp_hi));
        end
        if (v.exp_bad)                n_bad++;
        else if (v.exp_to)            n_to++;
        else if (v.exp_mask != '0)    n_ok++;
        check_stats($sformatf("v%0d", idx));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion",
                 checks);
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{64'h1300_0010_DEAD_BEEF, {8'd0, 8'd0, 8'd5, 8'd0}, 0, 4'b0010, 1'b0, 1'b0};
        vecs[1]  = '{64'h9123_4567_0000_0001, {8'd0, 8'd0, 8'd0, 8'd0}, 0, 4'b0000, 1'b1, 1'b0};
        vecs[2]  = '{64'hF5AB_CDEF_1234_5678, {8'd9, 8'd3, 8'd7, 8'd2}, 0, 4'b1111, 1'b0, 1'b0};
        vecs[3]  = '{64'h2700_0100_CAFE_F00D, {8'd0, 8'd0, 8'd0, 8'd0}, 0, 4'b0100, 1'b0, 1'b1};
        vecs[4]  = '{64'h0A00_0200_0000_00AA, {8'd0, 8'd0, 8'd0, 8'd20}, 0, 4'b0001, 1'b0, 1'b0};
        vecs[5]  = '{64'h3C00_0300_5555_AAAA, {8'd1, 8'd0, 8'd0, 8'd0}, 3, 4'b1000, 1'b0, 1'b0};
        vecs[6]  = '{64'h1100_0400_0000_0011, {8'd0, 8'd0, 8'd1, 8'd0}, 0, 4'b0010, 1'b0, 1'b0};
        vecs[7]  = '{64'h2200_0500_0000_0022, {8'd0, 8'd2, 8'd0, 8'd0}, 0, 4'b0100, 1'b0, 1'b0};
        vecs[8]  = '{64'hF100_0600_0000_0033, {8'd25, 8'd1, 8'd1, 8'd1}, 0, 4'b1111, 1'b0, 1'b1};
        vecs[9]  = '{64'h4000_0000_0000_0044, {8'd0, 8'd0, 8'd0, 8'd0}, 0, 4'b0000, 1'b1, 1'b0};
        vecs[10] = '{64'h3200_0800_1357_9BDF, {8'd4, 8'd0, 8'd0, 8'd0}, 0, 4'b1000, 1'b0, 1'b0};

        RESET_N  = 1'b0;
        IN_DATA  = '0;
        IN_VALID = 1'b0;
        CMD_ACK  = '0;
        #12;
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_in_rd", 64'(IN_RD), 64'd0);
        chk("rst_cmd_valid", 64'(CMD_VALID), 64'd0);
        chk("rst_cmd_fields", {CMD_OP, CMD_ADDR, CMD_ARG[31:0]} , 64'd0);
        chk("rst_errs", 64'({ERR_BADTGT, ERR_TIMEOUT}), 64'd0);
        check_stats("rst");
        tick();
        RESET_N = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Reset while a command to a silent target is outstanding.
        IN_DATA  = 64'h2800_0700_0000_0077;
        IN_VALID = 1'b1;
        tick();
        tick();
        IN_VALID = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (CMD_VALID != '0) break;
        end
        chk("rstmid_issued", 64'(CMD_VALID), 64'b0100);
        RESET_N = 1'b0;
        #1;
        chk("rstmid_cmd_valid", 64'(CMD_VALID), 64'd0);
        chk("rstmid_busy", 64'(BUSY), 64'd0);
        chk("rstmid_cmd_arg", 64'(CMD_ARG), 64'd0);
        tick();
        tick();
        RESET_N = 1'b1;
        n_ok = 0;
        n_bad = 0;
        n_to = 0;
        repeat (5) tick();
        chk("rstmid_no_replay_busy", 64'(BUSY), 64'd0);
        chk("rstmid_no_replay_valid", 64'(CMD_VALID), 64'd0);
        check_stats("rstmid");
        run_vec(10, vecs[10]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
